// File: rtl/control_fsm.sv
// control_fsm
//    Main control unit for a small multi-cycle MIPS-style datapath. Each
//    instruction walks FETCH -> DECODE -> EXECUTE and then, depending on its
//    class, MEM and/or WB before it retires. Every output is a Moore decode of
//    the state register and the opcode latched when FETCH is left, so no input
//    has a combinational path to an output.
//
// Ports
//    c_clk           rising-edge clock
//    c_rst           asynchronous active-low reset
//    c_i_en          run enable, sampled in IDLE and at retirement
//    c_i_opcode      6-bit opcode from decode, captured on the edge leaving FETCH
//    c_i_mem_ready   data memory has completed the access (held in MEM until 1)
//    c_o_ce          fetch clock-enable, high for the single FETCH cycle
//    c_o_RegDst .. c_o_MemtoReg   datapath controls
//    c_o_state       current state encoding (IDLE=0 .. TRAP=6)
//    c_o_illegal     trap flag, high while in TRAP
//    c_o_instr_cnt   16-bit wrapping retired-instruction count
//
// Build option
//    CONTROL_ILLEGAL_TRAP_EN  when defined, an unrecognised opcode parks the FSM
//                             in TRAP until reset; otherwise it retires as a NOP.

module control_fsm (
    input  logic        c_clk,
    input  logic        c_rst,
    input  logic        c_i_en,
    input  logic [5:0]  c_i_opcode,
    input  logic        c_i_mem_ready,
    output logic        c_o_ce,
    output logic        c_o_RegDst,
    output logic        c_o_RegWrite,
    output logic        c_o_ALUSrc,
    output logic        c_o_Branch,
    output logic        c_o_MemRead,
    output logic        c_o_MemWrite,
    output logic        c_o_MemtoReg,
    output logic [2:0]  c_o_state,
    output logic        c_o_illegal,
    output logic [15:0] c_o_instr_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        TRAP    = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  opcode_q;
    logic [15:0] instrCnt_q;
    logic        retire;

    logic        isRtype;
    logic        isLw;
    logic        isSw;
    logic        isBeq;
    logic        isIalu;
    logic        isKnown;
    logic        useImm;

    // Classify the latched opcode. Everything downstream (sequencing and
    // output decode) looks only at these flags, never at the live input.
    always_comb begin
        isRtype = (opcode_q == OP_RTYPE);
        isLw    = (opcode_q == OP_LW);
        isSw    = (opcode_q == OP_SW);
        isBeq   = (opcode_q == OP_BEQ);
        isIalu  = (opcode_q == OP_ADDI) || (opcode_q == OP_SLTI) ||
                  (opcode_q == OP_ANDI) || (opcode_q == OP_ORI);
        isKnown = isRtype || isLw || isSw || isBeq || isIalu;
        useImm  = isLw || isSw || isIalu;
    end

    // State register. Reset drops straight to IDLE, which also kills any
    // MemWrite in flight since the controls are decoded from this register.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode capture. FETCH always advances to DECODE, so sampling while in
    // FETCH is the edge that leaves FETCH; the value then holds until the
    // next instruction is fetched.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            opcode_q <= OP_RTYPE;
        end else if (state_q == FETCH) begin
            opcode_q <= c_i_opcode;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits. A reset
    // mid-instruction clears it before that instruction can retire.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            instrCnt_q <= 16'h0000;
        end else if (retire) begin
            instrCnt_q <= instrCnt_q + 16'd1;
        end
    end

    // Next-state logic. Each instruction class ends in a different state;
    // whichever state is final raises 'retire', and the common retirement
    // rule then picks FETCH or IDLE from c_i_en. The enable is deliberately
    // ignored everywhere else so a mid-instruction drop still completes.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (c_i_en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                if (isKnown) begin
                    state_d = EXECUTE;
                end else begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    retire  = 1'b1;
`endif
                end
            end
            EXECUTE: begin
                if (isBeq) begin
                    retire = 1'b1;
                end else if (isLw || isSw) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (c_i_mem_ready) begin
                    if (isLw) begin
                        state_d = WB;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            WB: begin
                retire = 1'b1;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (retire) begin
            state_d = c_i_en ? FETCH : IDLE;
        end
    end

    // Moore output decode. Controls default low, which covers IDLE, DECODE
    // and TRAP; only MEM can be reached by LW/SW, so MemRead/MemWrite need
    // no further qualification there.
    always_comb begin
        c_o_ce        = 1'b0;
        c_o_RegDst    = 1'b0;
        c_o_RegWrite  = 1'b0;
        c_o_ALUSrc    = 1'b0;
        c_o_Branch    = 1'b0;
        c_o_MemRead   = 1'b0;
        c_o_MemWrite  = 1'b0;
        c_o_MemtoReg  = 1'b0;
        c_o_state     = state_q;
        c_o_illegal   = (state_q == TRAP);
        c_o_instr_cnt = instrCnt_q;
        case (state_q)
            FETCH: begin
                c_o_ce = 1'b1;
            end
            EXECUTE: begin
                c_o_ALUSrc = useImm;
                c_o_Branch = isBeq;
            end
            MEM: begin
                c_o_ALUSrc   = useImm;
                c_o_MemRead  = isLw;
                c_o_MemWrite = isSw;
            end
            WB: begin
                c_o_ALUSrc   = useImm;
                c_o_RegWrite = 1'b1;
                c_o_RegDst   = isRtype;
                c_o_MemtoReg = isLw;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm
//    Scoreboard bench for control_fsm. A driver issues one cycle of stimulus
//    at a time and pushes what the instruction-level reference model says the
//    DUT must show during that cycle; a monitor on the falling edge pops and
//    compares. The model describes each instruction as the list of states it
//    visits and the controls each state carries, built from the class rules.

module tb_control_fsm;

    logic        c_clk = 1'b0;
    logic        c_rst;
    logic        c_i_en;
    logic [5:0]  c_i_opcode;
    logic        c_i_mem_ready;
    logic        c_o_ce;
    logic        c_o_RegDst;
    logic        c_o_RegWrite;
    logic        c_o_ALUSrc;
    logic        c_o_Branch;
    logic        c_o_MemRead;
    logic        c_o_MemWrite;
    logic        c_o_MemtoReg;
    logic [2:0]  c_o_state;
    logic        c_o_illegal;
    logic [15:0] c_o_instr_cnt;

    control_fsm dut (
        .c_clk         (c_clk),
        .c_rst         (c_rst),
        .c_i_en        (c_i_en),
        .c_i_opcode    (c_i_opcode),
        .c_i_mem_ready (c_i_mem_ready),
        .c_o_ce        (c_o_ce),
        .c_o_RegDst    (c_o_RegDst),
        .c_o_RegWrite  (c_o_RegWrite),
        .c_o_ALUSrc    (c_o_ALUSrc),
        .c_o_Branch    (c_o_Branch),
        .c_o_MemRead   (c_o_MemRead),
        .c_o_MemWrite  (c_o_MemWrite),
        .c_o_MemtoReg  (c_o_MemtoReg),
        .c_o_state     (c_o_state),
        .c_o_illegal   (c_o_illegal),
        .c_o_instr_cnt (c_o_instr_cnt)
    );

    always #5 c_clk = ~c_clk;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    // Control word layout: {ce, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg}
    localparam logic [7:0] M_CE       = 8'h80;
    localparam logic [7:0] M_REGDST   = 8'h40;
    localparam logic [7:0] M_REGWRITE = 8'h20;
    localparam logic [7:0] M_ALUSRC   = 8'h10;
    localparam logic [7:0] M_BRANCH   = 8'h08;
    localparam logic [7:0] M_MEMREAD  = 8'h04;
    localparam logic [7:0] M_MEMWRITE = 8'h02;
    localparam logic [7:0] M_MEMTOREG = 8'h01;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_NOP} kind_e;

    typedef struct packed {
        logic [2:0]  state;
        logic [7:0]  ctrl;
        logic        illegal;
        logic [15:0] cnt;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [15:0] modelCnt = 16'h0000;
    bit          inIdle = 1'b1;
    logic [5:0]  knownOps[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D};

    function automatic kind_e classify(input logic [5:0] op);
        case (op)
            6'h00:                      return K_R;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h04:                      return K_BEQ;
            6'h08, 6'h0A, 6'h0C, 6'h0D: return K_I;
            default:                    return K_NOP;
        endcase
    endfunction

    function automatic logic [5:0] rndOp();
        return 6'($urandom_range(63, 0));
    endfunction

    function automatic logic rndBit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [5:0] rndUnknown();
        logic [5:0] o;
        do o = rndOp(); while (classify(o) != K_NOP);
        return o;
    endfunction

    function automatic logic [7:0] actualCtrl();
        return {c_o_ce, c_o_RegDst, c_o_RegWrite, c_o_ALUSrc,
                c_o_Branch, c_o_MemRead, c_o_MemWrite, c_o_MemtoReg};
    endfunction

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expEntry_t e);
        checkValue("state",     16'(c_o_state),    16'(e.state));
        checkValue("controls",  16'(actualCtrl()), 16'(e.ctrl));
        checkValue("instr_cnt", c_o_instr_cnt,     e.cnt);
        checkValue("illegal",   16'(c_o_illegal),  16'(e.illegal));
    endtask

    // Monitor: every falling edge with an outstanding expectation is one
    // observed DUT cycle to be scored.
    always @(negedge c_clk) begin : monitor
        expEntry_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    // One cycle of stimulus plus the expected view of that same cycle.
    task automatic applyStimulus(input logic en, input logic [5:0] op, input logic rdy,
                                 input logic [2:0] st, input logic [7:0] ct, input logic il);
        expEntry_t e;
        @(posedge c_clk);
        #1;
        c_i_en        = en;
        c_i_opcode    = op;
        c_i_mem_ready = rdy;
        e.state   = st;
        e.ctrl    = ct;
        e.illegal = il;
        e.cnt     = modelCnt;
        expQ.push_back(e);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, rndOp(), rndBit(), S_IDLE, 8'h00, 1'b0);
        end
    endtask

    // Reference model for one instruction: list the states it must visit
    // with their controls, then play them out cycle by cycle. The opcode is
    // only valid in FETCH and ready only matters on the last MEM cycle, so
    // every other cycle gets random values to prove they are ignored.
    task automatic runInstr(input logic [5:0] op, input int waits, input bit enAfter, input bit midEnZero);
        kind_e      k;
        logic [7:0] immBit;
        logic [2:0] stList[$];
        logic [7:0] ctList[$];
        int         memSeen;
        bit         trapped;
        bit         last;
        logic       en;
        logic       rdy;
        logic [5:0] o;

        k       = classify(op);
        immBit  = (k == K_LW || k == K_SW || k == K_I) ? M_ALUSRC : 8'h00;
        trapped = 1'b0;
        memSeen = 0;

        if (inIdle) applyStimulus(1'b1, rndOp(), rndBit(), S_IDLE, 8'h00, 1'b0);

        stList.push_back(S_FETCH);  ctList.push_back(M_CE);
        stList.push_back(S_DECODE); ctList.push_back(8'h00);
        if (k != K_NOP) begin
            stList.push_back(S_EXECUTE);
            ctList.push_back(immBit | ((k == K_BEQ) ? M_BRANCH : 8'h00));
            if (k == K_LW || k == K_SW) begin
                for (int i = 0; i <= waits; i++) begin
                    stList.push_back(S_MEM);
                    ctList.push_back(immBit | ((k == K_LW) ? M_MEMREAD : M_MEMWRITE));
                end
            end
            if (k == K_R || k == K_I || k == K_LW) begin
                stList.push_back(S_WB);
                ctList.push_back(immBit | M_REGWRITE |
                                 ((k == K_R)  ? M_REGDST   : 8'h00) |
                                 ((k == K_LW) ? M_MEMTOREG : 8'h00));
            end
        end
`ifdef CONTROL_ILLEGAL_TRAP_EN
        else begin
            trapped = 1'b1;
            for (int i = 0; i < 3; i++) begin
                stList.push_back(S_TRAP);
                ctList.push_back(8'h00);
            end
        end
`endif

        for (int i = 0; i < stList.size(); i++) begin
            last = (i == stList.size() - 1);
            o    = (i == 0) ? op : rndOp();
            if (last && !trapped) en = enAfter;
            else if (midEnZero)   en = (i == 0);
            else                  en = rndBit();
            if (stList[i] == S_MEM) begin
                rdy = (memSeen >= waits);
                memSeen++;
            end else begin
                rdy = rndBit();
            end
            applyStimulus(en, o, rdy, stList[i], ctList[i], stList[i] == S_TRAP);
        end

        if (!trapped) begin
            modelCnt = modelCnt + 16'd1;
            inIdle   = !enAfter;
        end
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
    task automatic doReset(input string tag);
        @(negedge c_clk);
        #2;
        c_rst = 1'b0;
        #1;
        checkValue({tag, "_state"},    16'(c_o_state),    16'h0000);
        checkValue({tag, "_controls"}, 16'(actualCtrl()), 16'h0000);
        checkValue({tag, "_cnt"},      c_o_instr_cnt,     16'h0000);
        checkValue({tag, "_illegal"},  16'(c_o_illegal),  16'h0000);
        c_i_en = 1'b0;
        @(posedge c_clk);
        #2;
        c_rst    = 1'b1;
        modelCnt = 16'h0000;
        inIdle   = 1'b1;
    endtask

    // SW stalled in MEM, then reset lands while MemWrite is high.
    task automatic runSwAbort();
        if (inIdle) applyStimulus(1'b1, rndOp(), rndBit(), S_IDLE, 8'h00, 1'b0);
        applyStimulus(1'b1, 6'h2B,   rndBit(), S_FETCH,   M_CE,     1'b0);
        applyStimulus(1'b1, rndOp(), rndBit(), S_DECODE,  8'h00,    1'b0);
        applyStimulus(1'b1, rndOp(), rndBit(), S_EXECUTE, M_ALUSRC, 1'b0);
        applyStimulus(1'b1, rndOp(), 1'b0,     S_MEM,     M_ALUSRC | M_MEMWRITE, 1'b0);
        applyStimulus(1'b1, rndOp(), 1'b0,     S_MEM,     M_ALUSRC | M_MEMWRITE, 1'b0);
        @(negedge c_clk);
        #1;
        checkValue("abort_memwrite_held", 16'(c_o_MemWrite), 16'h0001);
        doReset("abort");
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [5:0] op;
        bit         ea;
        int         w;

        c_rst         = 1'b1;
        c_i_en        = 1'b0;
        c_i_opcode    = 6'h00;
        c_i_mem_ready = 1'b0;
        #1;
        c_rst = 1'b0;
        #1;
        checkValue("reset_state",    16'(c_o_state),    16'h0000);
        checkValue("reset_controls", 16'(actualCtrl()), 16'h0000);
        checkValue("reset_cnt",      c_o_instr_cnt,     16'h0000);
        checkValue("reset_illegal",  16'(c_o_illegal),  16'h0000);
        @(posedge c_clk);
        @(posedge c_clk);
        #2;
        c_rst = 1'b1;

        runIdle(2);

        // R-type, LW with three wait cycles, SW then BEQ
        runInstr(6'h00, 0, 1'b0, 1'b0);
        runIdle(1);
        runInstr(6'h23, 3, 1'b0, 1'b0);
        runInstr(6'h2B, 0, 1'b1, 1'b0);
        runInstr(6'h04, 0, 1'b0, 1'b0);

        // Enable dropped from DECODE onward: must still complete, then idle
        runInstr(6'h08, 0, 1'b0, 1'b1);
        runIdle(2);

        for (int n = 0; n < 80; n++) begin
            op = knownOps[$urandom_range(7, 0)];
`ifndef CONTROL_ILLEGAL_TRAP_EN
            if ($urandom_range(9, 0) == 0) op = rndUnknown();
`endif
            w  = $urandom_range(3, 0);
            ea = ($urandom_range(3, 0) != 0);
            runInstr(op, w, ea, 1'b0);
            if (!ea) runIdle($urandom_range(2, 0));
        end

        // Counter wrap: park in IDLE, preload 0xFFFF, retire one BEQ
        runInstr(6'h04, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, rndOp(), rndBit(), S_IDLE, 8'h00, 1'b0);
        @(negedge c_clk);
        #2;
        force dut.instrCnt_q = 16'hFFFF;
        #1;
        release dut.instrCnt_q;
        modelCnt = 16'hFFFF;
        #1;
        checkValue("cnt_preload", c_o_instr_cnt, 16'hFFFF);
        runInstr(6'h04, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, rndOp(), rndBit(), S_IDLE, 8'h00, 1'b0);
        @(negedge c_clk);
        #2;
        checkValue("cnt_wrap", c_o_instr_cnt, 16'h0000);

        // Reset during SW MEM, then a clean instruction afterwards
        runSwAbort();
        runInstr(6'h0D, 0, 1'b0, 1'b0);

        // Unrecognised opcode 0x3F
        runInstr(6'h3F, 0, 1'b1, 1'b0);
`ifdef CONTROL_ILLEGAL_TRAP_EN
        doReset("trap");
`endif
        runInstr(6'h00, 0, 1'b0, 1'b0);
        runIdle(1);

        @(negedge c_clk);
        #2;
        checkValue("queue_drained", 16'(expQ.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
